// File: rtl/p17_bulk_mux_pkg.sv
// Shared header field widths, FSM state types and the burst-length clamp
// for the bulk channel mux.
package p17_bulk_mux_pkg;

    localparam int HDR_CH_W  = 3;
    localparam int HDR_LEN_W = 5;

    typedef enum logic [1:0] {
        I_IDLE,
        I_HDR,
        I_DATA
    } in_st_t;

    typedef enum logic [1:0] {
        O_HDR,
        O_DATA,
        O_DROP
    } out_st_t;

    function automatic logic [HDR_LEN_W-1:0] clamp_len(
        input logic [HDR_LEN_W-1:0] len,
        input logic [HDR_LEN_W-1:0] lmax
    );
        return (len > lmax) ? lmax : len;
    endfunction

endpackage

// File: rtl/p17_bulk_chan_mux_if.sv
// Byte-stream link between the channel mux (master) and bulk_endp (slave):
// the IN path toward the endpoint and the OUT path coming back.
interface p17_bulk_chan_mux_if;
    import p17_bulk_mux_pkg::*;

    logic [HDR_CH_W+HDR_LEN_W-1:0] ep_in_data_o;
    logic                          ep_in_valid_o;
    logic                          ep_in_ready_i;
    logic [HDR_CH_W+HDR_LEN_W-1:0] ep_out_data_i;
    logic                          ep_out_valid_i;
    logic                          ep_out_ready_o;

    modport master (
        output ep_in_data_o,
        output ep_in_valid_o,
        input  ep_in_ready_i,
        input  ep_out_data_i,
        input  ep_out_valid_i,
        output ep_out_ready_o
    );

    modport slave (
        input  ep_in_data_o,
        input  ep_in_valid_o,
        output ep_in_ready_i,
        output ep_out_data_i,
        output ep_out_valid_i,
        input  ep_out_ready_o
    );

endinterface

// File: rtl/p17_rr_arb.sv
// Channel arbiter: round-robin from ptr upward with wrap, or fixed priority
// (lowest index wins, ptr ignored) when BULK_MUX_PRIO_EN is defined.
module p17_rr_arb #(
    parameter int NUM_CH = 4,
    parameter int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [IW-1:0]     idx
);

`ifdef BULK_MUX_PRIO_EN
    always_comb begin
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[IW'(i)]) idx = IW'(i);
        end
        gnt = '0;
        if (|req) gnt[idx] = 1'b1;
    end
`else
    int          c;
    logic [IW-1:0] ci;
    logic        found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        c     = 0;
        ci    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = int'(ptr) + i;
            if (c >= NUM_CH) c = c - NUM_CH;
            ci = IW'(c);
            if (!found && req[ci]) begin
                found = 1'b1;
                idx   = ci;
            end
        end
        gnt = '0;
        if (found) gnt[idx] = 1'b1;
    end
`endif

endmodule

// File: rtl/p17_bulk_chan_mux.sv
// Frames up to 8 app byte streams onto one bulk_endp FIFO pair and routes
// framed OUT data back by header channel. BULK_MUX_PRIO_EN: fixed priority.
module p17_bulk_chan_mux
    import p17_bulk_mux_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                  app_clk_i,
    input  logic                  rstn,
    input  logic [8*NUM_CH-1:0]   ch_in_data_i,
    input  logic [NUM_CH-1:0]     ch_in_valid_i,
    input  logic [5*NUM_CH-1:0]   ch_in_len_i,
    output logic [NUM_CH-1:0]     ch_in_ready_o,
    output logic [8*NUM_CH-1:0]   ch_out_data_o,
    output logic [NUM_CH-1:0]     ch_out_valid_o,
    input  logic [NUM_CH-1:0]     ch_out_ready_i,
    p17_bulk_chan_mux_if.master   ep,
    output logic                  bad_ch_o
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [HDR_LEN_W-1:0] LMAX = HDR_LEN_W'(MAX_BURST - 1);
    localparam logic [HDR_CH_W:0]    NCH  = (HDR_CH_W + 1)'(NUM_CH);

    in_st_t               in_st;
    logic [IW-1:0]        g;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        arb_idx;
    logic [NUM_CH-1:0]    arb_gnt;
    logic [HDR_LEN_W-1:0] in_len;
    logic [HDR_LEN_W-1:0] in_cnt;
    logic [HDR_LEN_W-1:0] len_sel;
    logic                 in_hs;

    out_st_t              o_st;
    logic                 out_en;
    logic [IW-1:0]        o_idx;
    logic [HDR_LEN_W-1:0] o_cnt;
    logic [HDR_CH_W-1:0]  hdr_ch;
    logic [HDR_LEN_W-1:0] hdr_len;
    logic                 o_hs;

    p17_rr_arb #(
        .NUM_CH(NUM_CH),
        .IW    (IW)
    ) u_arb (
        .req(ch_in_valid_i),
        .ptr(ptr),
        .gnt(arb_gnt),
        .idx(arb_idx)
    );

    assign len_sel = ch_in_len_i[int'(arb_idx)*HDR_LEN_W +: HDR_LEN_W];
    assign in_hs   = (in_st == I_DATA) & ep.ep_in_valid_o & ep.ep_in_ready_i;

    always_ff @(posedge app_clk_i or negedge rstn) begin
        if (!rstn) begin
            in_st  <= I_IDLE;
            g      <= '0;
            in_len <= '0;
            in_cnt <= '0;
        end else begin
            unique case (in_st)
                I_IDLE: if (|arb_gnt) begin
                    g      <= arb_idx;
                    in_len <= clamp_len(len_sel, LMAX);
                    in_st  <= I_HDR;
                end
                I_HDR: if (ep.ep_in_ready_i) begin
                    in_cnt <= in_len;
                    in_st  <= I_DATA;
                end
                I_DATA: if (in_hs) begin
                    if (in_cnt == '0) in_st <= I_IDLE;
                    else              in_cnt <= in_cnt - 1'b1;
                end
                default: in_st <= I_IDLE;
            endcase
        end
    end

`ifndef BULK_MUX_PRIO_EN
    // Pointer moves past the channel that just finished its frame.
    always_ff @(posedge app_clk_i or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (in_hs && in_cnt == '0) begin
            ptr <= (g == IW'(NUM_CH - 1)) ? '0 : g + 1'b1;
        end
    end
`else
    assign ptr = '0;
`endif

    always_comb begin
        ep.ep_in_valid_o = 1'b0;
        ep.ep_in_data_o  = '0;
        ch_in_ready_o    = '0;
        unique case (in_st)
            I_HDR: begin
                ep.ep_in_valid_o = 1'b1;
                ep.ep_in_data_o  = {HDR_CH_W'(g), in_len};
            end
            I_DATA: begin
                ep.ep_in_valid_o = ch_in_valid_i[g];
                ep.ep_in_data_o  = ch_in_data_i[int'(g)*8 +: 8];
                ch_in_ready_o[g] = ep.ep_in_ready_i & ch_in_valid_i[g];
            end
            default: ;
        endcase
    end

    assign hdr_ch  = ep.ep_out_data_i[HDR_LEN_W +: HDR_CH_W];
    assign hdr_len = ep.ep_out_data_i[HDR_LEN_W-1:0];
    assign o_hs    = ep.ep_out_valid_i & ep.ep_out_ready_o;

    // out_en keeps ep_out_ready_o low while reset is held.
    always_ff @(posedge app_clk_i or negedge rstn) begin
        if (!rstn) begin
            out_en   <= 1'b0;
            o_st     <= O_HDR;
            o_idx    <= '0;
            o_cnt    <= '0;
            bad_ch_o <= 1'b0;
        end else begin
            out_en <= 1'b1;
            unique case (o_st)
                O_HDR: if (o_hs) begin
                    o_cnt <= hdr_len;
                    o_idx <= IW'(hdr_ch);
                    if ({1'b0, hdr_ch} >= NCH) begin
                        bad_ch_o <= 1'b1;
                        o_st     <= O_DROP;
                    end else begin
                        o_st <= O_DATA;
                    end
                end
                O_DATA, O_DROP: if (o_hs) begin
                    if (o_cnt == '0) o_st <= O_HDR;
                    else             o_cnt <= o_cnt - 1'b1;
                end
                default: o_st <= O_HDR;
            endcase
        end
    end

    always_comb begin
        ep.ep_out_ready_o = 1'b0;
        ch_out_valid_o    = '0;
        unique case (o_st)
            O_HDR, O_DROP: ep.ep_out_ready_o = out_en;
            O_DATA: begin
                ch_out_valid_o[o_idx] = ep.ep_out_valid_i;
                ep.ep_out_ready_o     = ch_out_ready_i[o_idx];
            end
            default: ;
        endcase
    end

    assign ch_out_data_o = out_en ? {NUM_CH{ep.ep_out_data_i}} : '0;

endmodule

// File: tb/tb_p17_bulk_chan_mux.sv
// Directed scoreboard bench for p17_bulk_chan_mux (NUM_CH=4, MAX_BURST=8).
// Honors BULK_MUX_PRIO_EN for the arbitration order it expects.
module tb_p17_bulk_chan_mux;

    localparam int NCH = 4;

    logic               app_clk_i = 1'b0;
    logic               rstn;
    logic [8*NCH-1:0]   ch_in_data_i;
    logic [NCH-1:0]     ch_in_valid_i;
    logic [5*NCH-1:0]   ch_in_len_i;
    logic [NCH-1:0]     ch_in_ready_o;
    logic [8*NCH-1:0]   ch_out_data_o;
    logic [NCH-1:0]     ch_out_valid_o;
    logic [NCH-1:0]     ch_out_ready_i;
    logic               bad_ch_o;

    p17_bulk_chan_mux_if ep_if ();

    p17_bulk_chan_mux #(
        .NUM_CH   (NCH),
        .MAX_BURST(8)
    ) dut (
        .app_clk_i     (app_clk_i),
        .rstn          (rstn),
        .ch_in_data_i  (ch_in_data_i),
        .ch_in_valid_i (ch_in_valid_i),
        .ch_in_len_i   (ch_in_len_i),
        .ch_in_ready_o (ch_in_ready_o),
        .ch_out_data_o (ch_out_data_o),
        .ch_out_valid_o(ch_out_valid_o),
        .ch_out_ready_i(ch_out_ready_i),
        .ep            (ep_if),
        .bad_ch_o      (bad_ch_o)
    );

    always #5 app_clk_i = ~app_clk_i;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] b;
    } oexp_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_in[$];
    oexp_t       exp_out[$];
    oexp_t       oc;
    logic [7:0]  ie;
    logic [7:0]  sbuf [NCH][64];
    int          rd [NCH];
    int          wr [NCH];
    int          pops [NCH];
    logic [NCH-1:0] tk;
    int          p0;
    int          n;

    // Per-channel byte sources: valid while their buffer is non-empty.
    for (genvar k = 0; k < NCH; k++) begin : g_src
        assign ch_in_valid_i[k]       = rd[k] != wr[k];
        assign ch_in_data_i[k*8 +: 8] = sbuf[k][rd[k][5:0]];
    end

    always begin
        @(negedge app_clk_i);
        tk = ch_in_ready_o;
        @(posedge app_clk_i);
        #1;
        for (int k = 0; k < NCH; k++) begin
            if (tk[k] && rd[k] != wr[k]) begin
                rd[k]++;
                pops[k]++;
            end
        end
    end

    always @(negedge app_clk_i) begin
        if (rstn && ep_if.ep_in_valid_o && ep_if.ep_in_ready_i) begin
            checks++;
            assert (exp_in.size() != 0) else begin
                errors++;
                $error("FAIL ep_in_unexpected got %h exp none", ep_if.ep_in_data_o);
            end
            if (exp_in.size() != 0) begin
                ie = exp_in.pop_front();
                checks++;
                assert (ep_if.ep_in_data_o === ie) else begin
                    errors++;
                    $error("FAIL ep_in_byte got %h exp %h", ep_if.ep_in_data_o, ie);
                end
            end
        end
    end

    always @(negedge app_clk_i) begin
        if (rstn && |ch_out_valid_o) begin
            checks++;
            assert (exp_out.size() != 0) else begin
                errors++;
                $error("FAIL ch_out_unexpected got valid %b exp 0000", ch_out_valid_o);
            end
            if (exp_out.size() != 0) begin
                oc = exp_out[0];
                checks++;
                assert (ch_out_valid_o === (NCH'(1) << oc.ch)) else begin
                    errors++;
                    $error("FAIL ch_out_valid got %b exp %b", ch_out_valid_o, NCH'(1) << oc.ch);
                end
                if (ch_out_valid_o[oc.ch] && ch_out_ready_i[oc.ch]) begin
                    checks++;
                    assert (ch_out_data_o[int'(oc.ch)*8 +: 8] === oc.b) else begin
                        errors++;
                        $error("FAIL ch_out_byte ch %0d got %h exp %h", oc.ch, ch_out_data_o[int'(oc.ch)*8 +: 8], oc.b);
                    end
                    void'(exp_out.pop_front());
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge app_clk_i);
        #1;
    endtask

    task automatic push_src(input int k, input logic [7:0] b);
        sbuf[k][wr[k][5:0]] = b;
        wr[k]++;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while ((exp_in.size() != 0 || exp_out.size() != 0) && t < 300) begin
            tick();
            t++;
        end
        checks++;
        assert (exp_in.size() == 0 && exp_out.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain got in %0d out %0d left exp 0 0", tag, exp_in.size(), exp_out.size());
        end
        repeat (3) tick();
    endtask

    task automatic send_out(input logic [7:0] b);
        int  t = 0;
        logic done = 1'b0;
        ep_if.ep_out_data_i  = b;
        ep_if.ep_out_valid_i = 1'b1;
        while (!done && t < 100) begin
            @(negedge app_clk_i);
            done = ep_if.ep_out_ready_o;
            tick();
            t++;
        end
        ep_if.ep_out_valid_i = 1'b0;
        chk("ep_out_accept", 32'(done), 32'd1);
    endtask

    initial begin
        rstn                 = 1'b0;
        ch_in_len_i          = '0;
        ch_out_ready_i       = '0;
        ep_if.ep_in_ready_i  = 1'b0;
        ep_if.ep_out_data_i  = '0;
        ep_if.ep_out_valid_i = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            rd[k] = 0;
            wr[k] = 0;
            pops[k] = 0;
        end
        repeat (2) tick();
        chk("rst_ep_in_valid", 32'(ep_if.ep_in_valid_o), 0);
        chk("rst_ep_in_data", 32'(ep_if.ep_in_data_o), 0);
        chk("rst_ch_in_ready", 32'(ch_in_ready_o), 0);
        chk("rst_ch_out_valid", 32'(ch_out_valid_o), 0);
        chk("rst_ep_out_ready", 32'(ep_if.ep_out_ready_o), 0);
        chk("rst_bad_ch", 32'(bad_ch_o), 0);

        rstn                = 1'b1;
        ch_out_ready_i      = '1;
        ep_if.ep_in_ready_i = 1'b1;
        tick();
        chk("ep_out_ready_hdr", 32'(ep_if.ep_out_ready_o), 1);

        // Round-robin vs fixed priority between ch0 and ch3, one-byte frames.
        push_src(0, 8'hC0);
        push_src(0, 8'hC1);
        push_src(3, 8'hD0);
        push_src(3, 8'hD1);
`ifdef BULK_MUX_PRIO_EN
        exp_in = '{8'h00, 8'hC0, 8'h00, 8'hC1, 8'h60, 8'hD0, 8'h60, 8'hD1};
`else
        exp_in = '{8'h00, 8'hC0, 8'h60, 8'hD0, 8'h00, 8'hC1, 8'h60, 8'hD1};
`endif
        wait_done("rr");

        p0 = pops[2];
        ch_in_len_i[10 +: 5] = 5'd3;
        exp_in.push_back(8'h43);
        for (int i = 0; i < 4; i++) begin
            push_src(2, 8'hA0 + 8'(i));
            exp_in.push_back(8'hA0 + 8'(i));
        end
        wait_done("single");
        chk("ch2_ready_pulses", 32'(pops[2] - p0), 4);

        p0 = pops[1];
        ch_in_len_i[5 +: 5] = 5'd31;
        exp_in.push_back(8'h27);
        for (int i = 0; i < 8; i++) begin
            push_src(1, 8'hE0 + 8'(i));
            exp_in.push_back(8'hE0 + 8'(i));
        end
        wait_done("clamp");
        chk("clamp_bytes", 32'(pops[1] - p0), 8);

        exp_out.push_back({2'd1, 8'h11});
        exp_out.push_back({2'd1, 8'h22});
        exp_out.push_back({2'd1, 8'h33});
        ch_out_ready_i = 4'b1101;
        fork
            begin
                repeat (5) @(posedge app_clk_i);
                #1;
                ch_out_ready_i = '1;
            end
            begin
                send_out(8'h22);
                send_out(8'h11);
                send_out(8'h22);
                send_out(8'h33);
            end
        join
        wait_done("out_bp");
        chk("bad_ch_clear", 32'(bad_ch_o), 0);

        send_out(8'hA1);
        send_out(8'h5A);
        send_out(8'hA5);
        chk("bad_ch_set", 32'(bad_ch_o), 1);
        exp_out.push_back({2'd0, 8'h77});
        send_out(8'h00);
        send_out(8'h77);
        wait_done("bad");
        repeat (4) tick();
        chk("bad_ch_sticky", 32'(bad_ch_o), 1);

        // Abandon a ch0 frame after three of six bytes.
        p0 = pops[0];
        ch_in_len_i[0 +: 5] = 5'd5;
        exp_in = '{8'h05, 8'hF0, 8'hF1, 8'hF2};
        for (int i = 0; i < 6; i++) push_src(0, 8'hF0 + 8'(i));
        n = 0;
        while (pops[0] - p0 < 3 && n < 100) begin
            @(posedge app_clk_i);
            #2;
            n++;
        end
        chk("midrst_reach", 32'(pops[0] - p0), 3);
        rstn = 1'b0;
        #1;
        chk("midrst_consumed", 32'(exp_in.size()), 0);
        chk("midrst_ep_in_valid", 32'(ep_if.ep_in_valid_o), 0);
        chk("midrst_ep_in_data", 32'(ep_if.ep_in_data_o), 0);
        chk("midrst_ch_in_ready", 32'(ch_in_ready_o), 0);
        chk("midrst_ep_out_ready", 32'(ep_if.ep_out_ready_o), 0);
        chk("midrst_bad_ch", 32'(bad_ch_o), 0);
        rd[0] = wr[0];
        exp_in.delete();
        repeat (2) tick();
        rstn = 1'b1;
        ch_in_len_i = '0;
        push_src(2, 8'h92);
        push_src(0, 8'h90);
        exp_in = '{8'h00, 8'h90, 8'h40, 8'h92};
        wait_done("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/p17_bulk_chan_mux.md
Name: p17_bulk_chan_mux

Overview:
App-side channel multiplexer sitting between up to 8 application byte streams and the single app_in/app_out FIFO interface of p17_bulk_endp.
- IN direction: frames each granted channel's burst as one header byte {ch[2:0], len_m1[4:0]} followed by len bytes.
- OUT direction: parses the same framing and routes payload to the addressed channel.
- Whole block runs in the app_clk_i domain.

Parameters:
NUM_CH, 4, number of channels; legal 1..8.
MAX_BURST, 16, max bytes per frame; legal 1..32. ch_in_len_i values above MAX_BURST-1 are clamped to MAX_BURST-1.

Ports:
app_clk_i  in  1  clock for all logic.
rstn  in  1  reset, asynchronous, active-low.
ch_in_data_i  in  8*NUM_CH  per-channel IN byte; channel k uses bits [8k+7:8k].
ch_in_valid_i  in  NUM_CH  per-channel IN valid.
ch_in_len_i  in  5*NUM_CH  per-channel burst length minus 1; sampled at grant.
ch_in_ready_o  out  NUM_CH  per-channel IN consume strobe.
ch_out_data_o  out  8*NUM_CH  per-channel OUT byte; all lanes carry ep_out_data_i.
ch_out_valid_o  out  NUM_CH  per-channel OUT valid.
ch_out_ready_i  in  NUM_CH  per-channel OUT ready.
ep_in_data_o  out  8  byte to bulk_endp app_in_data_i.
ep_in_valid_o  out  1  to bulk_endp app_in_valid_i.
ep_in_ready_i  in  1  from bulk_endp app_in_ready_o.
ep_out_data_i  in  8  from bulk_endp app_out_data_o.
ep_out_valid_i  in  1  from bulk_endp app_out_valid_o.
ep_out_ready_o  out  1  to bulk_endp app_out_ready_i.
bad_ch_o  out  1  sticky; set when an OUT header addresses ch >= NUM_CH.

Behaviour:
Reset:
- All outputs 0.
- IN FSM in I_IDLE; OUT FSM in O_HDR.
- RR pointer = 0; counters = 0; bad_ch_o = 0.
- Reset mid-frame abandons the frame with no further bytes emitted or routed.

Handshake:
- All transfers complete on valid&ready in the same cycle.
- Granted channel must hold valid high and keep supplying bytes for the full committed length.
- Lowering valid mid-burst only stalls the burst; it never aborts it.

IN FSM:
- I_IDLE: if any ch_in_valid_i, the arbiter picks channel g, searching from the RR pointer upward with wrap. Register g and len_m1 = min(ch_in_len_i[g], MAX_BURST-1). Go to I_HDR next cycle.
- I_HDR: ep_in_valid_o = 1, ep_in_data_o = {g[2:0], len_m1}. On ep_in_ready_i: cnt = len_m1, go to I_DATA.
- I_DATA: ep_in_data_o = ch_in_data_i[g], ep_in_valid_o = ch_in_valid_i[g], ch_in_ready_o[g] = ep_in_ready_i & ch_in_valid_i[g]. Other channels' ready = 0.
  - On handshake with cnt == 0: go to I_IDLE and set the RR pointer to (g+1) mod NUM_CH.
  - Otherwise decrement cnt.
- Frame overhead: 1 header byte plus 1 idle arbitration cycle.

OUT FSM:
- O_HDR: ep_out_ready_o = 1. On ep_out_valid_i, latch ch = data[7:5] and cnt = data[4:0].
  - If ch >= NUM_CH: set bad_ch_o, go to O_DROP.
  - Otherwise go to O_DATA.
- O_DATA: ch_out_valid_o[ch] = ep_out_valid_i, ep_out_ready_o = ch_out_ready_i[ch]. On handshake: cnt == 0 -> O_HDR, else decrement.
- O_DROP: ep_out_ready_o = 1. Discard cnt+1 bytes, then go to O_HDR.

Other rules:
- IN and OUT FSMs are fully independent; simultaneous activity is legal.
- With NUM_CH = 1 the arbiter degenerates to always granting channel 0.
- Header ch field is zero-extended from $clog2(NUM_CH) bits.

Optional Feature:
BULK_MUX_PRIO_EN.
- Defined: the arbiter is fixed-priority (lowest index wins) and the RR pointer is removed.
- Undefined: round-robin as above.

Decomposition:
- Package p17_bulk_mux_pkg holds HDR_CH_W=3, HDR_LEN_W=5, the IN state enum (I_IDLE, I_HDR, I_DATA) and the OUT state enum (O_HDR, O_DATA, O_DROP).
- One sub-module, p17_rr_arb: NUM_CH request vector plus pointer in, one-hot grant and index out. Contains the BULK_MUX_PRIO_EN switch.

Test Plan:
- Single IN burst: ch2 valid, len_m1=3, bytes A0..A3 with ready held high -> ep_in sequence 0x43, A0, A1, A2, A3. ch_in_ready_o[2] pulses 4 times.
- RR fairness: ch0 and ch3 always valid, len_m1=0 -> headers alternate 0x00, 0x60, 0x00, 0x60 (fixed-priority build: 0x00 repeated).
- OUT routing with backpressure: ep_out stream 0x22, 11, 22, 33 with ch1 ready low for 5 cycles -> ch1 receives 11, 22, 33 in order with no loss. Other ch_out_valid_o stay 0.
- Bad channel: NUM_CH=4, OUT stream 0xA1, X, Y, then 0x00, Z -> X and Y dropped, bad_ch_o=1 and sticky, ch0 receives Z.
- Clamp: MAX_BURST=8, ch_in_len_i=31 -> header len field 7, exactly 8 data bytes emitted.
- Reset mid-frame: assert rstn low during I_DATA with cnt=2 -> all outputs 0 immediately. After release, next frame starts with a fresh header from ch0 priority.
